// File: rtl/pc_branch_ctrl_if.sv
// pc_branch_ctrl_if: EX-stage branch inputs and fetch/flush outputs of the PC controller.
interface pc_branch_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic             stall_i;
    logic             ex_valid;
    logic             ex_is_beq;
    logic             ex_is_bne;
    logic             ex_is_jump;
    logic             ex_zero;
    logic [PC_W-1:0]  ex_pc_plus1;
    logic [PC_W-1:0]  ex_offset;
    logic [25:0]      ex_jidx;
    logic [PC_W-1:0]  pc_o;
    logic [PC_W-1:0]  pc_plus1_o;
    logic             flush_ifid;
    logic             flush_idex;
    logic             redirect_o;
    logic             squash_o;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output stall_i, ex_valid, ex_is_beq, ex_is_bne, ex_is_jump, ex_zero,
               ex_pc_plus1, ex_offset, ex_jidx,
        input  pc_o, pc_plus1_o, flush_ifid, flush_idex, redirect_o, squash_o, taken_cnt
    );

    modport slave (
        input  stall_i, ex_valid, ex_is_beq, ex_is_bne, ex_is_jump, ex_zero,
               ex_pc_plus1, ex_offset, ex_jidx,
        output pc_o, pc_plus1_o, flush_ifid, flush_idex, redirect_o, squash_o, taken_cnt
    );
endinterface

// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl: program counter with EX-stage branch/jump redirect, IF/ID squash and stall arbitration.
module pc_branch_ctrl #(
    parameter int                PC_W          = 32,
    parameter logic [PC_W-1:0]   RESET_PC      = '0,
    parameter int                SQUASH_CYCLES = 2,
    parameter int                CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    pc_branch_ctrl_if.slave    bus
);
    localparam int SC_W = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES) : 1;
    localparam logic [SC_W-1:0] SC_INIT = SC_W'(SQUASH_CYCLES - 1);

    if (SQUASH_CYCLES < 1) begin : g_bad_squash
        $error("pc_branch_ctrl: SQUASH_CYCLES must be at least 1");
    end

    typedef enum logic {RUN, SQUASH} state_t;

    state_t           state_q, state_d;
    logic [SC_W-1:0]  sc_q, sc_d;
    logic [PC_W-1:0]  pc_q, pc_d, target;
    logic [CNT_W-1:0] cnt_q;
    logic             take_br, take_j, take;

    always_comb begin
        take_br = bus.ex_valid & ((bus.ex_is_beq & bus.ex_zero) | (bus.ex_is_bne & ~bus.ex_zero));
        take_j  = bus.ex_valid & bus.ex_is_jump;
        // reset gating keeps every redirect/flush output quiet while rst_n is low
        take    = rst_n & (state_q == RUN) & (take_br | take_j);
        target  = take_j ? {bus.ex_pc_plus1[PC_W-1:26], bus.ex_jidx}
                         : bus.ex_pc_plus1 + bus.ex_offset;
        pc_d    = take ? target : bus.stall_i ? pc_q : pc_q + PC_W'(1);
        state_d = state_q;
        sc_d    = sc_q;
        if (state_q == RUN) begin
            state_d = take ? SQUASH : RUN;
            sc_d    = take ? SC_INIT : sc_q;
        end else begin
            state_d = (sc_q == '0) ? RUN : SQUASH;
            sc_d    = sc_q - SC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            sc_q    <= '0;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            pc_q    <= pc_d;
            if (take && !(&cnt_q))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.pc_plus1_o = pc_q + PC_W'(1);
    assign bus.redirect_o = take;
    assign bus.flush_ifid = take;
    assign bus.flush_idex = take;
    assign bus.squash_o   = rst_n & (state_q == SQUASH);
    assign bus.taken_cnt  = cnt_q;
endmodule

// File: tb/tb_pc_branch_ctrl.sv
// tb_pc_branch_ctrl: directed vectors for pc_branch_ctrl; a CNT_W=2 twin shares stimulus for saturation.
module tb_pc_branch_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic        stall, valid, beq, bne, jmp, zero;
    logic [31:0] pcp1, offset;
    logic [25:0] jidx;

    pc_branch_ctrl_if #(.PC_W(32), .CNT_W(16)) u_if ();
    pc_branch_ctrl_if #(.PC_W(32), .CNT_W(2))  s_if ();

    pc_branch_ctrl #(.PC_W(32), .RESET_PC(32'h0), .SQUASH_CYCLES(2), .CNT_W(16))
        u_dut (.clk(clk), .rst_n(rst_n), .bus(u_if.slave));
    pc_branch_ctrl #(.PC_W(32), .RESET_PC(32'h0), .SQUASH_CYCLES(2), .CNT_W(2))
        s_dut (.clk(clk), .rst_n(rst_n), .bus(s_if.slave));

    assign u_if.stall_i = stall;       assign s_if.stall_i = stall;
    assign u_if.ex_valid = valid;      assign s_if.ex_valid = valid;
    assign u_if.ex_is_beq = beq;       assign s_if.ex_is_beq = beq;
    assign u_if.ex_is_bne = bne;       assign s_if.ex_is_bne = bne;
    assign u_if.ex_is_jump = jmp;      assign s_if.ex_is_jump = jmp;
    assign u_if.ex_zero = zero;        assign s_if.ex_zero = zero;
    assign u_if.ex_pc_plus1 = pcp1;    assign s_if.ex_pc_plus1 = pcp1;
    assign u_if.ex_offset = offset;    assign s_if.ex_offset = offset;
    assign u_if.ex_jidx = jidx;        assign s_if.ex_jidx = jidx;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; valid = 0; beq = 0; bne = 0; jmp = 0; zero = 0;
        pcp1 = '0; offset = '0; jidx = '0;
    endtask

    initial begin
        idle();
        rst_n = 0;
        tick();
        valid = 1; jmp = 1; jidx = 26'h55;
        #1;
        check("rst_redirect", {31'd0, u_if.redirect_o}, 32'd0);
        check("rst_flush", {31'd0, u_if.flush_idex}, 32'd0);
        tick();
        idle();
        rst_n = 1;
        #1;
        check("rst_pc", u_if.pc_o, 32'd0);
        check("rst_pc1", u_if.pc_plus1_o, 32'd1);
        check("rst_cnt", {16'd0, u_if.taken_cnt}, 32'd0);
        check("rst_squash", {31'd0, u_if.squash_o}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("seq_pc", u_if.pc_o, 32'(i));
            check("seq_flush", {31'd0, u_if.flush_ifid}, 32'd0);
        end
        // BEQ taken: 3 + (-2) = 1
        valid = 1; beq = 1; zero = 1; pcp1 = 32'd3; offset = 32'hFFFF_FFFE;
        #1;
        check("beq_redirect", {31'd0, u_if.redirect_o}, 32'd1);
        check("beq_flush_ifid", {31'd0, u_if.flush_ifid}, 32'd1);
        check("beq_flush_idex", {31'd0, u_if.flush_idex}, 32'd1);
        tick();
        idle();
        #1;
        check("beq_pc", u_if.pc_o, 32'd1);
        check("beq_sq1", {31'd0, u_if.squash_o}, 32'd1);
        check("beq_cnt", {16'd0, u_if.taken_cnt}, 32'd1);
        tick();
        check("beq_sq2", {31'd0, u_if.squash_o}, 32'd1);
        check("beq_pc2", u_if.pc_o, 32'd2);
        tick();
        check("beq_sq_end", {31'd0, u_if.squash_o}, 32'd0);
        check("beq_pc3", u_if.pc_o, 32'd3);
        // BNE with zero set: not taken
        valid = 1; bne = 1; zero = 1; pcp1 = 32'h40; offset = 32'h8;
        #1;
        check("bne_nt_flush", {31'd0, u_if.flush_ifid}, 32'd0);
        tick();
        idle();
        #1;
        check("bne_nt_pc", u_if.pc_o, 32'd4);
        // jump wins over stall
        stall = 1; valid = 1; jmp = 1; beq = 1; zero = 1; offset = 32'h4;
        pcp1 = 32'h1000_0004; jidx = 26'h20;
        #1;
        check("jmp_flush", {31'd0, u_if.flush_idex}, 32'd1);
        tick();
        idle();
        stall = 1;
        #1;
        check("jmp_pc", u_if.pc_o, 32'h1000_0020);
        tick();
        check("sq_stall_pc", u_if.pc_o, 32'h1000_0020);
        stall = 0;
        tick();
        check("sq_exit_pc", u_if.pc_o, 32'h1000_0021);
        check("sq_exit", {31'd0, u_if.squash_o}, 32'd0);
        check("jmp_cnt", {16'd0, u_if.taken_cnt}, 32'd2);
        // taken branch held through SQUASH, honoured again once back in RUN
        valid = 1; beq = 1; zero = 1; pcp1 = 32'h100; offset = 32'h10;
        #1;
        check("b2b_redirect1", {31'd0, u_if.redirect_o}, 32'd1);
        tick();
        pcp1 = 32'h200;
        #1;
        check("b2b_pc1", u_if.pc_o, 32'h110);
        check("b2b_ign1", {31'd0, u_if.redirect_o}, 32'd0);
        check("b2b_ign1_flush", {31'd0, u_if.flush_ifid}, 32'd0);
        tick();
        check("b2b_ign2", {31'd0, u_if.redirect_o}, 32'd0);
        check("b2b_pc2", u_if.pc_o, 32'h111);
        tick();
        check("b2b_pc3", u_if.pc_o, 32'h112);
        check("b2b_redirect2", {31'd0, u_if.redirect_o}, 32'd1);
        tick();
        idle();
        #1;
        check("b2b_pc4", u_if.pc_o, 32'h210);
        check("b2b_cnt", {16'd0, u_if.taken_cnt}, 32'd4);
        tick();
        tick();
        check("b2b_pc5", u_if.pc_o, 32'h212);
        // fifth redirect to 0xFFFFFFFF, then wrap
        valid = 1; jmp = 1; pcp1 = 32'hFC00_0000; jidx = 26'h3FF_FFFF;
        tick();
        idle();
        #1;
        check("max_pc", u_if.pc_o, 32'hFFFF_FFFF);
        check("cnt16", {16'd0, u_if.taken_cnt}, 32'd5);
        check("cnt2_sat", {30'd0, s_if.taken_cnt}, 32'd3);
        tick();
        check("wrap_pc", u_if.pc_o, 32'd0);
        check("wrap_sq", {31'd0, u_if.squash_o}, 32'd1);
        // reset mid-SQUASH
        rst_n = 0;
        #1;
        check("rst_sq_comb", {31'd0, u_if.squash_o}, 32'd0);
        tick();
        rst_n = 1;
        #1;
        check("rst_sq_pc", u_if.pc_o, 32'd0);
        check("rst_sq_state", {31'd0, u_if.squash_o}, 32'd0);
        check("rst_sq_cnt", {16'd0, u_if.taken_cnt}, 32'd0);
        tick();
        check("post_rst_pc", u_if.pc_o, 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_branch_ctrl.md
Name: pc_branch_ctrl

Overview:
- Owns the program counter and sequences control-flow changes for the 5-stage pipeline.
- Resolves BEQ, BNE and J in the EX stage and redirects the PC.
- Squashes the two younger instructions in IF and ID, and arbitrates between branch redirect, hazard stall and sequential fetch.
- PC is word-addressed: sequential fetch adds 1. Branch offsets are the sign-extended immediate, used unshifted (word units).

Parameters:
PC_W, 32, PC and address width
RESET_PC, 0, PC value loaded on reset
SQUASH_CYCLES, 2, cycles after a redirect during which EX branch inputs are ignored
CNT_W, 16, width of the taken-redirect counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active low
stall_i  input  1  load-use stall from hazard unit; hold PC
ex_valid  input  1  EX stage holds a valid instruction
ex_is_beq  input  1  EX instruction is BEQ
ex_is_bne  input  1  EX instruction is BNE
ex_is_jump  input  1  EX instruction is J
ex_zero  input  1  ALU zero flag for the EX instruction
ex_pc_plus1  input  PC_W  PC+1 of the EX instruction
ex_offset  input  PC_W  sign-extended branch immediate, word units
ex_jidx  input  26  jump index field
pc_o  output  PC_W  current fetch PC
pc_plus1_o  output  PC_W  pc_o + 1, to IF/ID
flush_ifid  output  1  load bubble into IF/ID at next edge
flush_idex  output  1  load bubble into ID/EX at next edge
redirect_o  output  1  redirect taken this cycle
squash_o  output  1  FSM in SQUASH
taken_cnt  output  CNT_W  saturating count of redirects

Behaviour:
- Reset: synchronous, sampled only on the clk edge while rst_n=0. Loads pc_o=RESET_PC, FSM=RUN, squash counter=0, taken_cnt=0.
- Combinational outputs under reset: flush_ifid=flush_idex=redirect_o=0, squash_o=0. pc_plus1_o=pc_o+1.
- Reset asserted mid-SQUASH or mid-redirect aborts the operation: the next cycle starts in RUN at RESET_PC.
- take_br = ex_valid & ((ex_is_beq & ex_zero) | (ex_is_bne & ~ex_zero)).
- take_j = ex_valid & ex_is_jump. take = (take_br | take_j) & (FSM==RUN).
- Branch target = ex_pc_plus1 + ex_offset, modulo 2^PC_W. Wraps silently, no flag.
- Jump target = {ex_pc_plus1[PC_W-1:26], ex_jidx}.
- If ex_is_jump and a branch flag are both set, the jump wins.
- redirect_o, flush_ifid and flush_idex all equal take, combinationally, in the same cycle. Squashed instructions are therefore replaced at the same edge the PC is redirected.
- Next PC priority, highest first:
  - take: pc_o <= target.
  - else stall_i: pc_o holds.
  - else: pc_o <= pc_o+1, wrapping 2^PC_W-1 to 0.
- A taken redirect overrides stall_i in the same cycle, because the EX instruction is older than the stalled one. The stall is dropped and flushes are asserted.
- FSM states:
  - RUN --take--> SQUASH, counter loaded with SQUASH_CYCLES-1.
  - SQUASH: decrement each cycle; when the counter is 0, return to RUN at the next edge.
  - SQUASH lasts exactly SQUASH_CYCLES cycles. squash_o=1 throughout.
  - In SQUASH, all EX branch/jump inputs are ignored: no redirect, no flush. stall_i still holds the PC.
  - SQUASH_CYCLES=0 is illegal. Enforce with a synthesis-time check.
- taken_cnt increments on each cycle with take=1 and saturates at all-ones.
- Latency: redirect decision to new pc_o is 1 clock edge.
- Back-to-back: a taken branch reaching EX in the first cycle after SQUASH ends is honoured normally.

Test Plan:
1. Reset with rst_n=0 for 2 cycles, then release; no branches -> pc_o = 0,1,2,3 on successive cycles; flushes stay 0.
2. pc_o=5; BEQ in EX, ex_zero=1, ex_pc_plus1=3, ex_offset=0xFFFFFFFE -> redirect_o=flush_ifid=flush_idex=1 that cycle; next pc_o=1; squash_o=1 for 2 cycles; taken_cnt=1.
3. BNE with ex_zero=1 (not taken), stall_i=0 -> no flush; pc_o increments by 1.
4. stall_i=1 with a taken J in EX at the same time, ex_pc_plus1=0x10000004, ex_jidx=0x20 -> pc_o=0x10000020; flushes asserted; the stall does not hold the PC.
5. Taken branch, then a second taken branch in EX during both SQUASH cycles -> second one ignored, no flush. A taken branch in the first RUN cycle after SQUASH is honoured.
6. pc_o=0xFFFFFFFF with no stall -> next pc_o=0. Assert rst_n=0 during SQUASH -> next cycle pc_o=RESET_PC, squash_o=0. Force CNT_W=2 and take 5 redirects -> taken_cnt saturates at 3.
